// File: rtl/ordered_sets_decoder.sv
// Receive-side lane ordered-set decoder: lane init (align on /K/, verify on /V/),
// then strips /SCP/../ECP/ framing and streams payload words with a last flag.
module ordered_sets_decoder #(
  parameter int DATA_W     = 16,
  parameter int ALIGN_CNT  = 4,
  parameter int VERIFY_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [1:0]        rx_isk,
  input  logic              rx_code_err,
  output logic              rx_aligned,
  output logic              rx_verified,
  output logic              axi_valid,
  output logic              axi_last,
  output logic [DATA_W-1:0] axi_data,
  output logic              frame_err
);

  localparam int CNT_MAX = (ALIGN_CNT > VERIFY_CNT) ? ALIGN_CNT : VERIFY_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_ALIGN  = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              in_frame;
  logic              held_valid;
  logic [DATA_W-1:0] held_data;

  logic is_k, is_v, is_scp, is_ecp, is_idle, is_data, is_unk;

  // Word classification; a /V/ word is also a /K/ word.
  always_comb begin
    is_k    = (rx_isk == 2'b10) && (rx_data[15:8] == 8'hBC);
    is_v    = is_k && (rx_data[7:0] == 8'hB5);
    is_scp  = (rx_isk == 2'b11) && (rx_data == 16'h5CFB);
    is_ecp  = (rx_isk == 2'b11) && (rx_data == 16'hFDFE);
    is_idle = (rx_isk == 2'b11) &&
              ((rx_data == 16'h1C1C) || (rx_data == 16'h7C7C) || (rx_data == 16'hF7F7));
    is_data = (rx_isk == 2'b00);
    is_unk  = !(is_k || is_scp || is_ecp || is_idle || is_data);
  end

  assign rx_aligned  = (state != S_ALIGN);
  assign rx_verified = (state == S_READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ALIGN;
      cnt        <= '0;
      in_frame   <= 1'b0;
      held_valid <= 1'b0;
      held_data  <= '0;
      axi_valid  <= 1'b0;
      axi_last   <= 1'b0;
      axi_data   <= '0;
      frame_err  <= 1'b0;
    end else begin
      axi_valid <= 1'b0;
      axi_last  <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid) begin
        if (rx_code_err) begin
          // Lane lost: restart init and drop any partial frame.
          frame_err  <= in_frame;
          state      <= S_ALIGN;
          cnt        <= '0;
          in_frame   <= 1'b0;
          held_valid <= 1'b0;
        end else begin
          case (state)
            S_ALIGN: begin
              if (is_k) begin
                if (cnt == CNT_W'(ALIGN_CNT - 1)) begin
                  state <= S_VERIFY;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end else begin
                cnt <= '0;
              end
            end
            S_VERIFY: begin
              if (is_v) begin
                if (cnt == CNT_W'(VERIFY_CNT - 1)) begin
                  state <= S_READY;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + CNT_W'(1);
                end
              end else if (!(is_k || is_idle)) begin
                cnt <= '0;
              end
            end
            S_READY: begin
              if (!in_frame) begin
                if (is_scp) in_frame <= 1'b1;
                else if (is_ecp) frame_err <= 1'b1;
              end else if (is_scp) begin
                frame_err  <= 1'b1;
                held_valid <= 1'b0;
              end else if (is_data) begin
                // One-word hold so the final word can carry last when ECP arrives.
                if (held_valid) begin
                  axi_valid <= 1'b1;
                  axi_data  <= held_data;
                end
                held_valid <= 1'b1;
                held_data  <= rx_data;
              end else if (is_ecp) begin
                if (held_valid) begin
                  axi_valid <= 1'b1;
                  axi_last  <= 1'b1;
                  axi_data  <= held_data;
                end
                in_frame   <= 1'b0;
                held_valid <= 1'b0;
              end else if (is_unk) begin
                frame_err  <= 1'b1;
                in_frame   <= 1'b0;
                held_valid <= 1'b0;
              end
            end
            default: state <= S_ALIGN;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ordered_sets_decoder.sv
// Bench for ordered_sets_decoder: directed lane-init/framing cases with literal
// expectations plus randomized episodes checked every cycle against a reference model.
module tb_ordered_sets_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic [1:0]  rx_isk;
  logic        rx_code_err;
  logic        rx_aligned, rx_verified, axi_valid, axi_last, frame_err;
  logic [15:0] axi_data;

  ordered_sets_decoder #(.DATA_W(16), .ALIGN_CNT(4), .VERIFY_CNT(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_isk(rx_isk),
    .rx_code_err(rx_code_err), .rx_aligned(rx_aligned), .rx_verified(rx_verified),
    .axi_valid(axi_valid), .axi_last(axi_last), .axi_data(axi_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  localparam int C_K = 0, C_V = 1, C_SCP = 2, C_ECP = 3, C_IDLE = 4, C_DATA = 5, C_UNK = 6;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: phase 0 = waiting for alignment, 1 = verifying, 2 = ready.
  int          m_phase;
  int          m_run;
  bit          m_in_frame;
  logic [15:0] held_q[$];
  logic [15:0] exp_q[$];
  bit          e_valid, e_last, e_ferr;
  logic [15:0] e_data;

  function automatic int classify(logic [1:0] k, logic [15:0] d);
    if (k == 2'b00) return C_DATA;
    if (k == 2'b10 && d == 16'hBCB5) return C_V;
    if (k == 2'b10 && d[15:8] == 8'hBC) return C_K;
    if (k == 2'b11 && d == 16'h5CFB) return C_SCP;
    if (k == 2'b11 && d == 16'hFDFE) return C_ECP;
    if (k == 2'b11 && (d == 16'h1C1C || d == 16'h7C7C || d == 16'hF7F7)) return C_IDLE;
    return C_UNK;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_in_frame = 0;
    held_q.delete();
    e_valid = 0; e_last = 0; e_ferr = 0; e_data = '0;
  endtask

  task automatic model_word(input logic v, input logic [1:0] k, input logic [15:0] d,
                            input logic err);
    int c;
    e_valid = 0; e_last = 0; e_ferr = 0;
    if (!v) return;
    if (err) begin
      e_ferr = m_in_frame;
      m_phase = 0; m_run = 0; m_in_frame = 0;
      held_q.delete();
      return;
    end
    c = classify(k, d);
    if (m_phase == 0) begin
      m_run = (c == C_K || c == C_V) ? m_run + 1 : 0;
      if (m_run == 4) begin m_phase = 1; m_run = 0; end
    end else if (m_phase == 1) begin
      if (c == C_V) m_run++;
      else if (c != C_K && c != C_IDLE) m_run = 0;
      if (m_run == 16) begin m_phase = 2; m_run = 0; end
    end else if (!m_in_frame) begin
      if (c == C_SCP) m_in_frame = 1;
      else if (c == C_ECP) e_ferr = 1;
    end else begin
      case (c)
        C_SCP: begin e_ferr = 1; held_q.delete(); end
        C_DATA: begin
          if (held_q.size() > 0) begin e_valid = 1; e_data = held_q.pop_front(); end
          held_q.push_back(d);
        end
        C_ECP: begin
          if (held_q.size() > 0) begin e_valid = 1; e_last = 1; e_data = held_q.pop_front(); end
          m_in_frame = 0;
        end
        C_UNK: begin e_ferr = 1; m_in_frame = 0; held_q.delete(); end
        default: ;
      endcase
    end
    if (e_valid) exp_q.push_back(e_data);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic compare_model();
    logic [15:0] want;
    chk("aligned", 16'(rx_aligned), 16'(m_phase >= 1));
    chk("verified", 16'(rx_verified), 16'(m_phase == 2));
    chk("axi_valid", 16'(axi_valid), 16'(e_valid));
    chk("axi_last", 16'(axi_last), 16'(e_last));
    chk("frame_err", 16'(frame_err), 16'(e_ferr));
    if (e_valid && axi_valid) begin
      want = exp_q.pop_front();
      chk("axi_data", axi_data, want);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] k, input logic [15:0] d, input logic err);
    rx_valid = v; rx_isk = k; rx_data = d; rx_code_err = err;
    model_word(v, k, d, err);
    @(posedge clk);
    #1;
    n_vec++;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1; rx_valid = 0; rx_isk = '0; rx_data = '0; rx_code_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    exp_q.delete();
    compare_model();
  endtask

  task automatic gen_word(input int c, output logic [1:0] k, output logic [15:0] d);
    logic [15:0] idles[3];
    idles[0] = 16'h1C1C; idles[1] = 16'h7C7C; idles[2] = 16'hF7F7;
    case (c)
      C_K:    begin k = 2'b10; d = {8'hBC, 8'($urandom_range(0, 255))}; end
      C_V:    begin k = 2'b10; d = 16'hBCB5; end
      C_SCP:  begin k = 2'b11; d = 16'h5CFB; end
      C_ECP:  begin k = 2'b11; d = 16'hFDFE; end
      C_IDLE: begin k = 2'b11; d = idles[$urandom_range(0, 2)]; end
      C_DATA: begin k = 2'b00; d = 16'($urandom); end
      default: begin k = 2'($urandom_range(1, 3)); d = 16'($urandom); end
    endcase
  endtask

  task automatic rnd_step(input int c, input int p_invalid, input int p_err);
    logic [1:0]  k;
    logic [15:0] d;
    gen_word(c, k, d);
    step(($urandom_range(0, 99) >= p_invalid), k, d, ($urandom_range(0, 999) < p_err));
  endtask

  function automatic int traffic_class();
    int r;
    r = $urandom_range(0, 99);
    if (r < 12) return C_SCP;
    if (r < 24) return C_ECP;
    if (r < 64) return C_DATA;
    if (r < 79) return C_IDLE;
    if (r < 87) return C_K;
    if (r < 95) return C_V;
    return C_UNK;
  endfunction

  initial begin
    model_reset();
    do_reset();
    chk("reset aligned", 16'(rx_aligned), 16'd0);
    chk("reset verified", 16'(rx_verified), 16'd0);
    chk("reset axi_valid", 16'(axi_valid), 16'd0);
    chk("reset frame_err", 16'(frame_err), 16'd0);

    // Four K words align; 3K + DATA + 3K does not.
    for (int i = 0; i < 4; i++) step(1, 2'b10, 16'hBC00, 0);
    chk("align after 4K", 16'(rx_aligned), 16'd1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 2'b10, 16'hBC00, 0);
    step(1, 2'b00, 16'h1234, 0);
    for (int i = 0; i < 3; i++) step(1, 2'b10, 16'hBC00, 0);
    chk("no align 3K-D-3K", 16'(rx_aligned), 16'd0);
    step(1, 2'b10, 16'hBC00, 0);
    chk("align 4th run", 16'(rx_aligned), 16'd1);

    // Verify: DATA at V #8 restarts; a 10-cycle rx_valid gap holds the count.
    for (int i = 0; i < 7; i++) begin
      step(1, 2'b10, 16'hBCB5, 0);
      step(1, 2'b11, 16'h1C1C, 0);
    end
    step(1, 2'b00, 16'h0BAD, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 2'b10, 16'hBCB5, 0);
      chk("verified progress", 16'(rx_verified), 16'(i == 15));
      if (i == 5) begin
        for (int j = 0; j < 10; j++) step(0, 2'b00, 16'h0000, 0);
        chk("gap aligned", 16'(rx_aligned), 16'd1);
        chk("gap verified", 16'(rx_verified), 16'd0);
      end
      if (i < 15) step(1, 2'b11, 16'h1C1C, 0);
    end

    // Basic frame.
    step(1, 2'b11, 16'h5CFB, 0);
    step(1, 2'b00, 16'h1111, 0);
    chk("f1 no early out", 16'(axi_valid), 16'd0);
    step(1, 2'b00, 16'h2222, 0);
    chk("f1 w0 valid", 16'(axi_valid), 16'd1);
    chk("f1 w0 data", axi_data, 16'h1111);
    chk("f1 w0 last", 16'(axi_last), 16'd0);
    step(1, 2'b11, 16'hF7F7, 0);
    chk("f1 idle quiet", 16'(axi_valid), 16'd0);
    step(1, 2'b00, 16'h3333, 0);
    chk("f1 w1 data", axi_data, 16'h2222);
    step(1, 2'b11, 16'hFDFE, 0);
    chk("f1 w2 data", axi_data, 16'h3333);
    chk("f1 w2 last", 16'(axi_last), 16'd1);

    // Empty frame, stray ECP, back-to-back SCP.
    step(1, 2'b11, 16'h5CFB, 0);
    step(1, 2'b11, 16'hFDFE, 0);
    chk("empty valid", 16'(axi_valid), 16'd0);
    chk("empty ferr", 16'(frame_err), 16'd0);
    step(1, 2'b11, 16'hFDFE, 0);
    chk("stray ecp ferr", 16'(frame_err), 16'd1);
    step(1, 2'b11, 16'h5CFB, 0);
    step(1, 2'b00, 16'hAAAA, 0);
    step(1, 2'b11, 16'h5CFB, 0);
    chk("double scp ferr", 16'(frame_err), 16'd1);
    chk("double scp valid", 16'(axi_valid), 16'd0);
    step(1, 2'b00, 16'hBBBB, 0);
    chk("bbbb held", 16'(axi_valid), 16'd0);
    step(1, 2'b11, 16'hFDFE, 0);
    chk("bbbb data", axi_data, 16'hBBBB);
    chk("bbbb last", 16'(axi_last), 16'd1);

    // Code error mid-frame.
    step(1, 2'b11, 16'h5CFB, 0);
    step(1, 2'b00, 16'h4444, 0);
    step(1, 2'b00, 16'h5555, 0);
    chk("pre-err data", axi_data, 16'h4444);
    step(1, 2'b00, 16'h0000, 1);
    chk("err ferr", 16'(frame_err), 16'd1);
    chk("err aligned", 16'(rx_aligned), 16'd0);
    chk("err verified", 16'(rx_verified), 16'd0);
    chk("err valid", 16'(axi_valid), 16'd0);
    step(1, 2'b11, 16'hFDFE, 0);
    chk("post-err quiet", 16'(axi_valid), 16'd0);

    // Randomized episodes: init bursts with disturbances, then mixed traffic.
    for (int ep = 0; ep < 6; ep++) begin
      for (int i = 0; i < int'($urandom_range(3, 6)); i++)
        rnd_step(($urandom_range(0, 9) == 0) ? C_DATA : C_K, 10, 0);
      for (int i = 0; i < int'($urandom_range(16, 22)); i++) begin
        if ($urandom_range(0, 1) == 1) rnd_step(($urandom_range(0, 1) == 1) ? C_IDLE : C_K, 10, 0);
        rnd_step(($urandom_range(0, 19) == 0) ? C_DATA : C_V, 10, 0);
      end
      for (int i = 0; i < 150; i++) rnd_step(traffic_class(), 10, 6);
      if ($urandom_range(0, 2) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
